tick_watchdog: RTL and testbench
================================

# tick_watchdog

- Sits directly downstream of the periodic tick generator and checks its one-cycle `tick` pulse train against a nominal period with a tolerance window.
- Declares `locked` after LOCK_CNT consecutive in-window intervals.
- Flags early and late ticks with one-cycle pulses, keeps a sticky `fault`, and reports the last measured interval and a saturating error count to the supervisor.

## Interface
- PERIOD, 12502: nominal tick interval in clock cycles
- TOL, 2: allowed deviation; window MIN=PERIOD-TOL .. MAX=PERIOD+TOL inclusive
- LOCK_CNT, 4: consecutive good intervals required to lock (≥1)
- CBITS, 14: interval counter/`period` width; must satisfy MAX+1 < 2^CBITS and TOL < PERIOD

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle tick pulse from upstream generator (synchronous to clk)
- clr  in  1  clears sticky `fault`
- locked  out  1  interval train is within tolerance
- early  out  1  one-cycle pulse: tick arrived with interval < MIN
- late  out  1  one-cycle pulse: no tick within MAX cycles
- fault  out  1  sticky: early/late event occurred while locked
- period  out  CBITS  last measured interval
- err_cnt  out  8  saturating count of early+late events

## Operation
- Interval I = t1 - t0 between consecutive tick cycles t0 and t1.
- The internal gap counter saturates at MAX+1.
- States:
  - IDLE: waiting for first tick. Tick -> ACQ, good count=0. No measurement is made.
  - ACQ, on tick:
    - MIN≤I≤MAX: good count +1; if it reaches LOCK_CNT -> LOCKED.
    - I<MIN: `early` pulse, good count=0, stay ACQ; this tick becomes the new t0.
  - ACQ, no tick for MAX cycles: `late` pulse, -> IDLE.
  - LOCKED, on tick:
    - In-window tick: stay.
    - Early tick: `early` pulse, `fault`=1, -> ACQ, good count=0.
  - LOCKED, timeout: `late` pulse, `fault`=1, -> IDLE.
- `period`:
  - Loaded with I on every measured tick, in-window or early.
  - Unchanged on timeout and on the first tick out of IDLE.
- `err_cnt`: +1 per early or late pulse; saturates at 255.
- `fault`:
  - Set by an early/late event in LOCKED only. An ACQ event does not set it.
  - Cleared by `clr`. Set wins when set and `clr` occur in the same cycle.
- `locked` = (state==LOCKED), registered.
- `tick` held high for consecutive cycles: each high cycle is a separate tick (I=1, early unless MIN≤1).

## Timing
- All outputs registered. Event at cycle t (tick sampled at edge ending cycle t) -> response visible in cycle t+1.
- Timeout:
  - Last tick at t0 with no tick in t0+1..t0+MAX -> `late`=1 in cycle t0+MAX+1, state IDLE at that same edge.
  - A tick at exactly t0+MAX is in-window.
  - A tick at t0+MAX+1 is processed in IDLE (starts acquisition).
- Lock: the LOCK_CNT-th good tick at cycle t -> `locked`=1 from cycle t+1.
- Loss of lock: `locked` falls in the same cycle `early`/`late` rises.
- `early`/`late` are exactly one cycle wide; never both in one cycle.
- Reset (rst=0), immediately and asynchronously:
  - State IDLE, gap counter and good count 0.
  - `locked`, `early`, `late`, `fault`=0; `period`=0; `err_cnt`=0.
  - Ticks ignored while held.
  - After release, the first tick is treated as the IDLE first tick.
- Reset mid-operation discards any partial measurement; no late/early pulse results from it.

## Test plan
All scenarios use PERIOD=10, TOL=1 (window 9..11), LOCK_CNT=3, CBITS=5.
- Ticks every 10 cycles from cycle 5: `locked`=1 from cycle 36 (cycle after 4th tick); `period`=10; no `early`/`late`; `err_cnt`=0.
- Locked, then tick 8 cycles after previous: `early` one cycle; `period`=8; `fault`=1; `locked`=0; `err_cnt`=1. Three further 10-cycle intervals -> relock.
- Locked with last tick at t0, ticks stop: `late`=1 only in cycle t0+12; `locked`=0; `fault`=1; `period` still 10. A tick at t0+12 restarts acquisition with no `early`.
- Intervals 9, 11, 9 after first tick: all accepted, lock. Tick at t0+12 instead: `late` then new acquisition.
- `clr` coincident with a locked-state early event: `fault` stays 1. `clr` alone next cycle: `fault`=0 in the following cycle.
- Assert rst low mid-ACQ between edges: all outputs 0 immediately. Separately, drive 300 early events: `err_cnt` holds at 255.

Source files
------------

// File: rtl/tick_watchdog_if.sv
// Bundle between the tick source/supervisor and the tick watchdog.
// master drives tick/clr and observes status; slave is the watchdog itself.
interface tick_watchdog_if #(
    parameter int CBITS = 14
);
    logic             tick;
    logic             clr;
    logic             locked;
    logic             early;
    logic             late;
    logic             fault;
    logic [CBITS-1:0] period;
    logic [7:0]       err_cnt;

    modport master (
        output tick, clr,
        input  locked, early, late, fault, period, err_cnt
    );

    modport slave (
        input  tick, clr,
        output locked, early, late, fault, period, err_cnt
    );
endinterface

// File: rtl/tick_watchdog.sv
// Tick watchdog: measures the interval between one-cycle tick pulses,
// acquires lock after LOCK_CNT consecutive in-window intervals, and reports
// early/late events, a sticky fault, the last interval and an error count.
module tick_watchdog #(
    parameter int PERIOD   = 12502,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 4,
    parameter int CBITS    = 14
) (
    input  logic           clk,
    input  logic           rst,
    tick_watchdog_if.slave bus
);
    localparam int MIN   = PERIOD - TOL;
    localparam int MAX   = PERIOD + TOL;
    localparam int GBITS = $clog2(LOCK_CNT + 1);

    localparam logic [CBITS-1:0] MIN_C  = CBITS'(MIN);
    localparam logic [CBITS-1:0] MAX_C  = CBITS'(MAX);
    localparam logic [CBITS-1:0] SAT_C  = CBITS'(MAX + 1);
    localparam logic [GBITS-1:0] LOCK_C = GBITS'(LOCK_CNT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CBITS-1:0] gap_q, gap_d;
    logic [GBITS-1:0] good_q, good_d;
    logic             early_d, late_d, meas_d;

    logic             locked_q, early_q, late_q, fault_q;
    logic [CBITS-1:0] period_q;
    logic [7:0]       err_q;

    // Next-state decode: classify each tick against the window and detect timeouts.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        gap_d   = (gap_q == SAT_C) ? gap_q : gap_q + CBITS'(1);
        early_d = 1'b0;
        late_d  = 1'b0;
        meas_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tick) begin
                    state_d = ACQ;
                    good_d  = '0;
                    gap_d   = CBITS'(1);
                end
            end
            ACQ: begin
                if (bus.tick) begin
                    gap_d  = CBITS'(1);
                    meas_d = 1'b1;
                    if (gap_q < MIN_C) begin
                        early_d = 1'b1;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + GBITS'(1);
                        if (good_q + GBITS'(1) == LOCK_C)
                            state_d = LOCKED;
                    end
                end else if (gap_q == MAX_C) begin
                    late_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (bus.tick) begin
                    gap_d  = CBITS'(1);
                    meas_d = 1'b1;
                    if (gap_q < MIN_C) begin
                        early_d = 1'b1;
                        good_d  = '0;
                        state_d = ACQ;
                    end
                end else if (gap_q == MAX_C) begin
                    late_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered status outputs.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            fault_q  <= 1'b0;
            period_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            good_q   <= good_d;
            locked_q <= (state_d == LOCKED);
            early_q  <= early_d;
            late_q   <= late_d;
            if (meas_d)
                period_q <= gap_q;
            if ((early_d || late_d) && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
            // Set has priority over clear when both happen together.
            if (state_q == LOCKED && (early_d || late_d))
                fault_q <= 1'b1;
            else if (bus.clr)
                fault_q <= 1'b0;
        end
    end

    assign bus.locked  = locked_q;
    assign bus.early   = early_q;
    assign bus.late    = late_q;
    assign bus.fault   = fault_q;
    assign bus.period  = period_q;
    assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_tick_watchdog.sv
// Self-checking bench for tick_watchdog with PERIOD=10, TOL=1, LOCK_CNT=3.
// The reference model works on tick timestamps: it remembers when the last
// reference tick happened and derives intervals by subtraction.
module tb_tick_watchdog;
    localparam int PERIOD   = 10;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 3;
    localparam int CBITS    = 5;
    localparam int MIN      = PERIOD - TOL;
    localparam int MAX      = PERIOD + TOL;

    logic clk;
    logic rst;

    tick_watchdog_if #(.CBITS(CBITS)) bus();

    tick_watchdog #(
        .PERIOD(PERIOD), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .CBITS(CBITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Reference model state
    int t0;          // cycle of the reference tick, -1 when waiting for a first tick
    int good;        // consecutive in-window intervals while acquiring
    bit lk;
    bit exp_early, exp_late, exp_fault;
    int exp_period, exp_err;

    bit pat[$];

    function automatic logic [16:0] dut_vec();
        return {bus.locked, bus.early, bus.late, bus.fault, bus.period, bus.err_cnt};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {lk, exp_early, exp_late, exp_fault, CBITS'(exp_period), 8'(exp_err)};
    endfunction

    task automatic reset_model();
        t0 = -1; good = 0; lk = 0;
        exp_early = 0; exp_late = 0; exp_fault = 0;
        exp_period = 0; exp_err = 0;
    endtask

    task automatic model(input bit t, input bit c);
        bit was_lk;
        bit ev;
        int iv;
        was_lk = lk;
        exp_early = 0;
        exp_late  = 0;
        if (t0 < 0) begin
            if (t) begin
                t0 = cyc;
                good = 0;
            end
        end else begin
            iv = cyc - t0;
            if (t) begin
                exp_period = iv;
                if (iv < MIN) begin
                    exp_early = 1;
                    lk = 0;
                    good = 0;
                end else if (!lk) begin
                    good++;
                    if (good == LOCK_CNT) lk = 1;
                end
                t0 = cyc;
            end else if (iv == MAX) begin
                exp_late = 1;
                lk = 0;
                t0 = -1;
            end
        end
        ev = exp_early | exp_late;
        if (ev && exp_err < 255) exp_err++;
        if (ev && was_lk) exp_fault = 1;
        else if (c)       exp_fault = 0;
    endtask

    task automatic step(input bit t, input bit c);
        bus.tick = t;
        bus.clr  = c;
        @(posedge clk);
        model(t, c);
        cyc++;
        #1;
    endtask

    task automatic add_gap(input int n);
        for (int i = 1; i < n; i++) pat.push_back(1'b0);
        pat.push_back(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.tick = 1'b1;
        bus.clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (dut_vec() !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), 17'd0);
        end
        bus.tick = 1'b0;
        rst = 1'b1;
        reset_model();
    endtask

    task automatic test_lock();
        pat.delete();
        add_gap(5);
        repeat (3) add_gap(10);
        foreach (pat[i]) begin
            step(pat[i], 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL lock_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if ({bus.locked, bus.period, bus.err_cnt, bus.early, bus.late} !== {1'b1, 5'd10, 8'd0, 2'b00}) begin
            tests_failed++;
            $display("FAIL lock_result got=%b/%0d/%0d exp=1/10/0", bus.locked, bus.period, bus.err_cnt);
        end
    endtask

    task automatic test_early();
        pat.delete();
        add_gap(8);
        foreach (pat[i]) begin
            step(pat[i], 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL early_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if ({bus.early, bus.late, bus.period, bus.fault, bus.locked, bus.err_cnt} !== {2'b10, 5'd8, 2'b10, 8'd1}) begin
            tests_failed++;
            $display("FAIL early_result got e=%b p=%0d f=%b l=%b err=%0d exp e=1 p=8 f=1 l=0 err=1",
                     bus.early, bus.period, bus.fault, bus.locked, bus.err_cnt);
        end
        pat.delete();
        repeat (3) add_gap(10);
        foreach (pat[i]) begin
            step(pat[i], 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL relock_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if (bus.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock got=%b exp=1", bus.locked);
        end
    endtask

    task automatic test_late();
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL late_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if ({bus.late, bus.early, bus.locked, bus.fault, bus.period, bus.err_cnt} !== {4'b1001, 5'd10, 8'd2}) begin
            tests_failed++;
            $display("FAIL late_result got late=%b lk=%b f=%b p=%0d err=%0d exp late=1 lk=0 f=1 p=10 err=2",
                     bus.late, bus.locked, bus.fault, bus.period, bus.err_cnt);
        end
        step(1'b1, 1'b0);
        tests_run++;
        if ({bus.early, bus.late, bus.period} !== {2'b00, 5'd10} || dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL late_restart got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_window();
        pat.delete();
        add_gap(9);
        add_gap(11);
        add_gap(9);
        foreach (pat[i]) begin
            step(pat[i], 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL window_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if ({bus.locked, bus.period} !== {1'b1, 5'd9}) begin
            tests_failed++;
            $display("FAIL window_lock got lk=%b p=%0d exp lk=1 p=9", bus.locked, bus.period);
        end
        repeat (11) step(1'b0, 1'b0);
        tests_run++;
        if ({bus.late, bus.locked} !== 2'b10 || dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL window_timeout got=%h exp=%h", dut_vec(), exp_vec());
        end
        step(1'b1, 1'b0);
        tests_run++;
        if ({bus.late, bus.early} !== 2'b00 || dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL window_reacq got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_clr();
        pat.delete();
        repeat (3) add_gap(10);
        foreach (pat[i]) begin
            step(pat[i], 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL clr_lock_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        step(1'b0, 1'b1);
        tests_run++;
        if ({bus.fault, bus.locked} !== 2'b01) begin
            tests_failed++;
            $display("FAIL clr_plain got f=%b lk=%b exp f=0 lk=1", bus.fault, bus.locked);
        end
        repeat (6) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        tests_run++;
        if ({bus.early, bus.fault, bus.period} !== {2'b11, 5'd8} || dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL clr_set_wins got=%h exp=%h", dut_vec(), exp_vec());
        end
        step(1'b0, 1'b1);
        tests_run++;
        if (bus.fault !== 1'b0 || dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL clr_after got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int n;
        pat.delete();
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 7) n = $urandom_range(MIN, MAX);
            else                          n = $urandom_range(1, MAX + 3);
            add_gap(n);
        end
        foreach (pat[i]) begin
            step(pat[i], ($urandom_range(0, 15) == 0));
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (MAX + 2) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if (dut_vec() !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_async got=%h exp=%h", dut_vec(), 17'd0);
        end
        bus.tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (dut_vec() !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_hold got=%h exp=%h", dut_vec(), 17'd0);
        end
        bus.tick = 1'b0;
        rst = 1'b1;
        reset_model();
        pat.delete();
        add_gap(3);
        add_gap(10);
        foreach (pat[i]) begin
            step(pat[i], 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL post_reset_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if ({bus.period, bus.err_cnt} !== {5'd10, 8'd0}) begin
            tests_failed++;
            $display("FAIL post_reset got p=%0d err=%0d exp p=10 err=0", bus.period, bus.err_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL sat_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        repeat (3) step(1'b0, 1'b0);
        tests_run++;
        if (bus.err_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL err_saturate got=%0d exp=255", bus.err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_early();
        test_late();
        test_window();
        test_clr();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
